// File: rtl/t_toggle_counter.sv
// Multi-bit T-register / up-down counter with parallel load.
// Complementary outputs, combinational terminal count, registered ovf pulse.
module t_toggle_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);

  localparam logic [1:0] M_TOG  = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ovf_nxt;
  logic             w_all1;
  logic             w_zero;

  assign w_all1 = &r_q;
  assign w_zero = ~|r_q;

  always_comb begin
    w_q_nxt   = r_q;
    w_ovf_nxt = 1'b0;
    if (en) begin
      unique case (mode)
        M_TOG: w_q_nxt = r_q ^ t;
        M_UP: begin
          if (w_all1) begin
            w_q_nxt   = SATURATE ? r_q : '0;
            w_ovf_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q + WIDTH'(1);
          end
        end
        M_DOWN: begin
          if (w_zero) begin
            w_q_nxt   = SATURATE ? r_q : '1;
            w_ovf_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q - WIDTH'(1);
          end
        end
        M_LOAD: w_q_nxt = d;
        default: w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign q   = r_q;
  assign qb  = ~r_q;
  assign ovf = r_ovf;
  assign tc  = ((mode == M_UP) && w_all1) ||
               ((mode == M_DOWN) && w_zero);

endmodule

// File: tb/tb_t_toggle_counter.sv
// Directed bench: wrapping and saturating instances driven in lockstep,
// expected results queued at drive time and popped after each edge.
module tb_t_toggle_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t;
  logic [3:0] d;
  logic [3:0] q0, qb0, q1, qb1;
  logic       tc0, ovf0, tc1, ovf1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] q0;
    logic       ovf0;
    logic [3:0] q1;
    logic       ovf1;
  } exp_t;

  exp_t sb[$];
  logic [3:0] mq0, mq1;

  t_toggle_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(q0), .qb(qb0), .tc(tc0), .ovf(ovf0)
  );

  t_toggle_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(q1), .qb(qb1), .tc(tc1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference next-state: returns {ovf, q}
  function automatic logic [4:0] mdl(input logic [3:0] cq,
                                     input logic e, input logic [1:0] m,
                                     input logic [3:0] tt,
                                     input logic [3:0] dd,
                                     input bit sat);
    logic [3:0] nq;
    logic       no;
    nq = cq;
    no = 1'b0;
    if (e) begin
      case (m)
        2'b00: nq = cq ^ tt;
        2'b01: begin
          if (cq == 4'hF) begin
            no = 1'b1;
            nq = sat ? 4'hF : 4'h0;
          end else nq = cq + 4'd1;
        end
        2'b10: begin
          if (cq == 4'h0) begin
            no = 1'b1;
            nq = sat ? 4'h0 : 4'hF;
          end else nq = cq - 4'd1;
        end
        default: nq = dd;
      endcase
    end
    return {no, nq};
  endfunction

  function automatic logic exp_tc(input logic [3:0] cq,
                                  input logic [1:0] m);
    return (m == 2'b01 && cq == 4'hF) || (m == 2'b10 && cq == 4'h0);
  endfunction

  task automatic step(input string tag, input logic r, input logic e,
                      input logic [1:0] m, input logic [3:0] tt,
                      input logic [3:0] dd);
    exp_t       ex;
    logic [4:0] n0, n1;
    @(negedge clk);
    rst = r; en = e; mode = m; t = tt; d = dd;
    #1;
    chk({tag, ".tc0"}, {3'b0, tc0}, {3'b0, exp_tc(mq0, m)});
    chk({tag, ".tc1"}, {3'b0, tc1}, {3'b0, exp_tc(mq1, m)});
    if (r) begin
      n0 = 5'b0;
      n1 = 5'b0;
    end else begin
      n0 = mdl(mq0, e, m, tt, dd, 1'b0);
      n1 = mdl(mq1, e, m, tt, dd, 1'b1);
    end
    mq0 = n0[3:0];
    mq1 = n1[3:0];
    ex = '{q0: n0[3:0], ovf0: n0[4], q1: n1[3:0], ovf1: n1[4]};
    sb.push_back(ex);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s.sb got %0d exp %0d", tag, 0, 1);
    end
    if (sb.size() != 0) begin
      ex = sb.pop_front();
      chk({tag, ".q0"}, q0, ex.q0);
      chk({tag, ".qb0"}, qb0, ~ex.q0);
      chk({tag, ".ovf0"}, {3'b0, ovf0}, {3'b0, ex.ovf0});
      chk({tag, ".q1"}, q1, ex.q1);
      chk({tag, ".qb1"}, qb1, ~ex.q1);
      chk({tag, ".ovf1"}, {3'b0, ovf1}, {3'b0, ex.ovf1});
    end
  endtask

  // Called just after an edge: pulse rst between edges
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, ".q0"}, q0, 4'h0);
    chk({tag, ".qb0"}, qb0, 4'hF);
    chk({tag, ".ovf0"}, {3'b0, ovf0}, 4'h0);
    chk({tag, ".q1"}, q1, 4'h0);
    chk({tag, ".qb1"}, qb1, 4'hF);
    chk({tag, ".ovf1"}, {3'b0, ovf1}, 4'h0);
    mq0 = 4'h0;
    mq1 = 4'h0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b01; t = '0; d = '0;
    mq0 = 4'h0; mq1 = 4'h0;

    step("rst_a", 1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
    step("rst_b", 1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
    step("rst_c", 1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
    step("rel",   1'b0, 1'b1, 2'b01, 4'h0, 4'h0);

    step("ld0",   1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
    step("tog_a", 1'b0, 1'b1, 2'b00, 4'h5, 4'h0);
    step("tog_b", 1'b0, 1'b1, 2'b00, 4'h5, 4'h0);
    step("tog_c", 1'b0, 1'b1, 2'b00, 4'hA, 4'h0);
    step("tog_0", 1'b0, 1'b1, 2'b00, 4'h0, 4'h0);
    step("tog_f", 1'b0, 1'b1, 2'b00, 4'hF, 4'h0);

    step("ldE",   1'b0, 1'b1, 2'b11, 4'h0, 4'hE);
    step("up_a",  1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    step("up_b",  1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    step("up_c",  1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    step("up_d",  1'b0, 1'b1, 2'b01, 4'h0, 4'h0);

    step("ld1",   1'b0, 1'b1, 2'b11, 4'h0, 4'h1);
    step("dn_a",  1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
    step("dn_b",  1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
    step("dn_c",  1'b0, 1'b1, 2'b10, 4'h0, 4'h0);

    step("ldF",   1'b0, 1'b1, 2'b11, 4'h0, 4'hF);
    step("en0",   1'b0, 1'b0, 2'b11, 4'h0, 4'hA);
    step("en1",   1'b0, 1'b1, 2'b11, 4'h0, 4'hA);
    step("ldup",  1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    step("hold",  1'b0, 1'b0, 2'b10, 4'hF, 4'h3);

    step("ld0b",  1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
    step("dnov",  1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
    mid_reset("arst_ovf");

    step("ld6",   1'b0, 1'b1, 2'b11, 4'h0, 4'h6);
    step("cnt7",  1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
    mid_reset("arst_cnt");
    step("post",  1'b0, 1'b1, 2'b01, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_toggle_counter.md
Name: t_toggle_counter

Overview:
- Parametrised multi-bit successor to the single-bit T flip-flop.
- Holds a WIDTH-bit register with complementary outputs.
- Supports per-bit toggle (T-register bank), synchronous up/down counting and parallel load.
- Used as a general toggle/count register in lab designs and as a building block for dividers and timers.

Parameters:
WIDTH, 8, register width in bits (>=2)
SATURATE, 0, 0 = counter wraps at terminal value; 1 = counter clamps at terminal value

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  operation enable; 0 = hold
mode  input  2  00 toggle-mask, 01 count up, 10 count down, 11 load
t  input  WIDTH  per-bit toggle mask (mode 00)
d  input  WIDTH  parallel load value (mode 11)
q  output  WIDTH  register value
qb  output  WIDTH  bitwise complement of q, always
tc  output  1  combinational terminal count
ovf  output  1  registered one-cycle overflow/underflow pulse

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous and active-high. While rst=1: q=0, qb=all ones, ovf=0, regardless of clk. Release takes effect at the first rising clk edge with rst=0.
- qb is derived from the same state as q. Invariant qb == ~q holds at every instant, including during reset.
- All updates occur on the rising edge of clk when rst=0.
- en=0: q holds; ovf=0 on that edge.
- en=1, mode 00: q <= q ^ t. t=0 holds; t=all ones inverts every bit. ovf=0.
- en=1, mode 01: q <= q + 1 (mod 2^WIDTH).
  - If q == all ones: SATURATE=0 gives q <= 0; SATURATE=1 keeps q at all ones.
  - ovf=1 for that one edge in both cases.
- en=1, mode 10: q <= q - 1.
  - If q == 0: SATURATE=0 gives q <= all ones; SATURATE=1 keeps q at 0.
  - ovf=1 for that one edge in both cases.
- en=1, mode 11: q <= d. ovf=0. Loading a terminal value does not itself pulse ovf.
- tc (combinational): 1 when (mode==01 and q==all ones) or (mode==10 and q==0); else 0. tc is independent of en.
- ovf is registered. It is high exactly one cycle after the wrapping/clamping edge. It is cleared on the next edge unless another terminal step occurs, so it stays high on consecutive clamped steps in SATURATE=1.
- Latency: q and ovf change at the edge following input setup. No pipelining.
- Mode changes take effect immediately at the next edge; no state is carried between modes.
- Reset mid-operation: asserting rst at any time forces q=0, qb=all ones, ovf=0 asynchronously, discarding any pending step.
- X/undefined mode is not supported; the bench drives only the four legal codes.

Test Plan:
- Reset: WIDTH=4; hold rst=1 across 3 edges with en=1, mode=01 -> q=0000, qb=1111, ovf=0. Deassert rst -> next edge q=0001.
- Toggle: WIDTH=4, q=0000, en=1, mode=00, t=0101 for 2 edges -> q=0101 then 0000. t=0000 -> q holds; qb==~q each cycle.
- Up wrap: WIDTH=4, SATURATE=0, load 1110, mode=01 for 3 edges -> q=1111 (tc=1), then 0000 with ovf=1 for one cycle, then 0001 with ovf=0.
- Down saturate: WIDTH=4, SATURATE=1, load 0001, mode=10 for 3 edges -> q=0000, 0000, 0000. ovf=0, then 1, then 1. tc=1 while q=0.
- Enable/load: mode=11, d=1010, en=0 -> q unchanged. en=1 -> q=1010, ovf=0. Switch to mode=01 next edge -> q=1011.
- Async reset mid-count: q=0111 counting up; rst pulsed high between edges -> q=0000 and qb=1111 immediately, before the next clk edge, and ovf=0.
